// File: rtl/izh_pkg.sv
// Shared encodings, 2.16 fixed-point constants and the saturation helper
// for the Izhikevich neuron array.
package izh_pkg;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_I = 3'd4,
    SEL_V = 3'd5,
    SEL_U = 3'd6
  } cfg_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Constants are expressed in the default 18-bit 2.16 format
  localparam logic signed [17:0] K14   = 18'sh1_6666;
  localparam logic signed [17:0] VPEAK = 18'sh0_4CCC;
  localparam logic signed [17:0] RST_V = 18'sh3_4CCD;
  localparam logic signed [17:0] RST_U = 18'sh3_CCCD;
  localparam logic signed [17:0] RST_C = 18'sh3_599A;
  localparam logic signed [17:0] RST_D = 18'sh0_051E;
  localparam logic [3:0]         RST_A = 4'd1;
  localparam logic [3:0]         RST_B = 4'd2;

  // Clamp x into the signed range of a w-bit word (w <= 31)
  function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                             input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/izh_neuron_array_if.sv
// Configuration bus of the neuron array: register write port plus ready.
interface izh_neuron_array_if #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned W         = 18
);
  logic                         cfg_we;
  logic [$clog2(N_NEURONS)-1:0] cfg_addr;
  logic [2:0]                   cfg_sel;
  logic [W-1:0]                 cfg_data;
  logic                         cfg_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sel, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/izh_update.sv
// Combinational Izhikevich update for one neuron: owns the single v*v multiplier,
// applies saturation and the spike reset.
module izh_update
  import izh_pkg::*;
#(
  parameter int unsigned W    = 18,
  parameter int unsigned FRAC = 16
) (
  input  logic signed [W-1:0] i_v,
  input  logic signed [W-1:0] i_u,
  input  logic [3:0]          i_a,
  input  logic [3:0]          i_b,
  input  logic signed [W-1:0] i_c,
  input  logic signed [W-1:0] i_d,
  input  logic signed [W-1:0] i_i,
  input  logic                i_hold,
  output logic signed [W-1:0] o_v_next,
  output logic signed [W-1:0] o_u_next,
  output logic                o_fire
);
  localparam int unsigned WS = W + 4;
  localparam int unsigned PW = 2 * W;
  localparam logic signed [W-1:0] C_K14   = W'(K14);
  localparam logic signed [W-1:0] C_VPEAK = W'(VPEAK);

  logic signed [PW-1:0] w_prod;
  logic signed [W:0]    w_vv;
  logic signed [WS-1:0] w_sum_v;
  logic signed [WS-1:0] w_v_wide;
  logic signed [WS-1:0] w_du;
  logic signed [WS-1:0] w_u_wide;
  logic signed [WS-1:0] w_u_spk;
  logic signed [W-1:0]  w_v_new;
  logic signed [W-1:0]  w_u_new;
  logic signed [W-1:0]  w_u_rst;

  assign w_prod = PW'(i_v) * PW'(i_v);
  // Square rescaled to the W.FRAC grid; the product sign sits above the kept bits
  assign w_vv = {w_prod[PW-1], W'(w_prod >>> FRAC)};

  always_comb begin
    w_sum_v  = WS'(w_vv) + WS'(i_v) + WS'(i_v >>> 2) + WS'(C_K14 >>> 2)
             - WS'(i_u >>> 2) + WS'(i_i >>> 2);
    w_v_wide = WS'(i_v) + (w_sum_v >>> 2);
    w_du     = WS'(i_v >>> i_b) - WS'(i_u);
    w_u_wide = WS'(i_u) + ((w_du >>> i_a) >>> 4);
    w_u_spk  = WS'(i_u) + WS'(i_d);
    w_v_new  = W'(sat(32'(w_v_wide), W));
    w_u_new  = W'(sat(32'(w_u_wide), W));
    w_u_rst  = W'(sat(32'(w_u_spk), W));

    o_fire   = !i_hold && (i_v > C_VPEAK);
    o_v_next = w_v_new;
    o_u_next = w_u_new;
    if (i_hold) begin
      o_v_next = i_c;
    end else if (o_fire) begin
      o_v_next = i_c;
      o_u_next = w_u_rst;
    end
  end
endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: step_i sweeps all neurons, one per clock.
// Define REFRACTORY_EN to add a per-neuron refractory down-counter.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned W             = 18,
  parameter int unsigned FRAC          = 16,
  parameter int unsigned REFRACT_STEPS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [N_NEURONS-1:0]         spike_o,
  output logic                         overrun_o,
  izh_neuron_array_if.slave            cfg,
  input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
  output logic [7:0]                   mon_v
);
  localparam int unsigned AW = $clog2(N_NEURONS);
  localparam logic signed [W-1:0] C_RST_V = W'(RST_V);
  localparam logic signed [W-1:0] C_RST_U = W'(RST_U);
  localparam logic signed [W-1:0] C_RST_C = W'(RST_C);
  localparam logic signed [W-1:0] C_RST_D = W'(RST_D);

  if (N_NEURONS < 2 || N_NEURONS > 16 || (N_NEURONS & (N_NEURONS - 1)) != 0 ||
      FRAC > W - 2 || REFRACT_STEPS == 0) begin : g_param_check
    $error("izh_neuron_array: unsupported parameter set");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_busy;
  logic                  w_last;
  logic [AW-1:0]         r_k;
  logic [N_NEURONS-1:0]  r_acc;
  logic [N_NEURONS-1:0]  w_acc_nxt;
  logic [N_NEURONS-1:0]  r_spike;
  logic                  r_done;
  logic                  r_overrun;
  logic [7:0]            r_mon;

  logic signed [W-1:0]   r_v [N_NEURONS];
  logic signed [W-1:0]   r_u [N_NEURONS];
  logic signed [W-1:0]   r_c [N_NEURONS];
  logic signed [W-1:0]   r_d [N_NEURONS];
  logic signed [W-1:0]   r_i [N_NEURONS];
  logic [3:0]            r_a [N_NEURONS];
  logic [3:0]            r_b [N_NEURONS];

  logic signed [W-1:0]   w_v_next;
  logic signed [W-1:0]   w_u_next;
  logic                  w_fire;
  logic                  w_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (step_i) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_last = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_busy = 1'b1;
        w_last = (r_k == AW'(N_NEURONS - 1));
      end
      default: ;
    endcase
  end

  izh_update #(
    .W    (W),
    .FRAC (FRAC)
  ) u_update (
    .i_v      (r_v[r_k]),
    .i_u      (r_u[r_k]),
    .i_a      (r_a[r_k]),
    .i_b      (r_b[r_k]),
    .i_c      (r_c[r_k]),
    .i_d      (r_d[r_k]),
    .i_i      (r_i[r_k]),
    .i_hold   (w_hold),
    .o_v_next (w_v_next),
    .o_u_next (w_u_next),
    .o_fire   (w_fire)
  );

  assign w_acc_nxt = r_acc | (N_NEURONS'(w_fire) << r_k);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_acc     <= '0;
      r_spike   <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_mon     <= '0;
      for (int unsigned n = 0; n < N_NEURONS; n++) begin
        r_v[n] <= C_RST_V;
        r_u[n] <= C_RST_U;
        r_c[n] <= C_RST_C;
        r_d[n] <= C_RST_D;
        r_i[n] <= '0;
        r_a[n] <= RST_A;
        r_b[n] <= RST_B;
      end
    end else begin
      r_done <= 1'b0;
      r_mon  <= r_v[mon_sel][W-1 -: 8];
      if (step_i && w_busy) r_overrun <= 1'b1;
      if (w_busy) begin
        r_v[r_k] <= w_v_next;
        r_u[r_k] <= w_u_next;
        r_acc    <= w_acc_nxt;
        r_k      <= r_k + AW'(1);
        if (w_last) begin
          r_done  <= 1'b1;
          r_spike <= w_acc_nxt;
        end
      end else begin
        if (step_i) begin
          r_k   <= '0;
          r_acc <= '0;
        end
        // Updates only run while busy, so idle-time writes never collide with write-back
        if (cfg.cfg_we) begin
          case (cfg_sel_e'(cfg.cfg_sel))
            SEL_A:   r_a[cfg.cfg_addr] <= cfg.cfg_data[3:0];
            SEL_B:   r_b[cfg.cfg_addr] <= cfg.cfg_data[3:0];
            SEL_C:   r_c[cfg.cfg_addr] <= cfg.cfg_data;
            SEL_D:   r_d[cfg.cfg_addr] <= cfg.cfg_data;
            SEL_I:   r_i[cfg.cfg_addr] <= cfg.cfg_data;
            SEL_V:   r_v[cfg.cfg_addr] <= cfg.cfg_data;
            SEL_U:   r_u[cfg.cfg_addr] <= cfg.cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef REFRACTORY_EN
  localparam int unsigned RW = ($clog2(REFRACT_STEPS + 1) < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
  logic [RW-1:0] r_ref [N_NEURONS];

  assign w_hold = (r_ref[r_k] != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < N_NEURONS; n++) r_ref[n] <= '0;
    end else if (w_busy) begin
      if (w_hold)      r_ref[r_k] <= r_ref[r_k] - RW'(1);
      else if (w_fire) r_ref[r_k] <= RW'(REFRACT_STEPS);
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  assign busy_o        = w_busy;
  assign done_o        = r_done;
  assign spike_o       = r_spike;
  assign overrun_o     = r_overrun;
  assign mon_v         = r_mon;
  assign cfg.cfg_ready = !w_busy;
endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed + random bench for izh_neuron_array against an arithmetic neuron model.
module tb_izh_neuron_array;
  localparam int     NN    = 4;
  localparam longint K14   = 91750;   // 1.4 in 2.16
  localparam longint VPEAK = 19660;   // 0.30 in 2.16
  localparam int     REFR  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_i;
  logic       busy_o, done_o, overrun_o;
  logic [3:0] spike_o;
  logic [1:0] mon_sel;
  logic [7:0] mon_v;

  izh_neuron_array_if #(.N_NEURONS(NN), .W(18)) cfg_if ();

  izh_neuron_array #(
    .N_NEURONS(NN), .W(18), .FRAC(16), .REFRACT_STEPS(REFR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .busy_o(busy_o), .done_o(done_o),
    .spike_o(spike_o), .overrun_o(overrun_o), .cfg(cfg_if),
    .mon_sel(mon_sel), .mon_v(mon_v)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference neuron state, plain signed integers in 2.16 units
  int mv[NN], mu[NN], ma[NN], mb[NN], mc[NN], md[NN], mi[NN];
  int mspike;
`ifdef REFRACTORY_EN
  int mref[NN];
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat18(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic int to_s18(input int x);
    int t;
    t = x & 'h3FFFF;
    return (t >= 131072) ? t - 262144 : t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NN; k++) begin
      mv[k] = to_s18('h34CCD); mu[k] = to_s18('h3CCCD);
      ma[k] = 1; mb[k] = 2;
      mc[k] = to_s18('h3599A); md[k] = 'h051E; mi[k] = 0;
`ifdef REFRACTORY_EN
      mref[k] = 0;
`endif
    end
  endtask

  task automatic model_write(input int n, input int sel, input int data);
    case (sel)
      0: ma[n] = data & 15;
      1: mb[n] = data & 15;
      2: mc[n] = to_s18(data);
      3: md[n] = to_s18(data);
      4: mi[n] = to_s18(data);
      5: mv[n] = to_s18(data);
      6: mu[n] = to_s18(data);
      default: ;
    endcase
  endtask

  task automatic model_step();
    mspike = 0;
    for (int k = 0; k < NN; k++) begin
      longint v, u, vv, vn, un;
      v  = mv[k];
      u  = mu[k];
      vv = ((v * v) >>> 16) % 262144;
      vn = sat18(v + ((vv + v + (v >>> 2) + (K14 >>> 2) - (u >>> 2) + (longint'(mi[k]) >>> 2)) >>> 2));
      un = sat18(u + (((v >>> mb[k]) - u) >>> (ma[k] + 4)));
`ifdef REFRACTORY_EN
      if (mref[k] > 0) begin
        mv[k] = mc[k]; mu[k] = int'(un); mref[k]--;
        continue;
      end
`endif
      if (v > VPEAK) begin
        mv[k] = mc[k];
        mu[k] = int'(sat18(u + md[k]));
        mspike |= (1 << k);
`ifdef REFRACTORY_EN
        mref[k] = REFR;
`endif
      end else begin
        mv[k] = int'(vn);
        mu[k] = int'(un);
      end
    end
  endtask

  task automatic cfg_write(input int n, input int sel, input int data, input bit lands);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_addr = 2'(n);
    cfg_if.cfg_sel  = 3'(sel);
    cfg_if.cfg_data = 18'(data);
    @(posedge clk); #1;
    cfg_if.cfg_we = 1'b0;
    if (lands) model_write(n, sel, data);
  endtask

  task automatic check_mon(input string tag);
    for (int k = 0; k < NN; k++) begin
      mon_sel = 2'(k);
      @(posedge clk); #1;
      check($sformatf("%s:mon%0d", tag, k), mon_v, (mv[k] & 'h3FFFF) >> 10);
    end
  endtask

  task automatic wait_done(input string tag, input int start_cyc);
    int cyc;
    bit got;
    cyc = start_cyc;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o) got = 1'b1;
    end
    check({tag, ":latency"}, got ? cyc : -1, NN + 1);
  endtask

  task automatic run_step(input string tag);
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    check({tag, ":busy"}, busy_o, 1);
    wait_done(tag, 1);
    model_step();
    check({tag, ":spike"}, spike_o, mspike);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, done_o, 0);
    check_mon(tag);
  endtask

  initial begin
    int dones;
    bit seen;
    rst_n = 1'b0; step_i = 1'b0; mon_sel = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_sel = '0; cfg_if.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", busy_o, 0);
    check("rst:done", done_o, 0);
    check("rst:spike", spike_o, 0);
    check("rst:overrun", overrun_o, 0);
    check("rst:mon", mon_v, 0);
    check("rst:ready", cfg_if.cfg_ready, 1);
    rst_n = 1'b1;
    model_reset();
    check_mon("post_rst");

    // First step from reset with I=0
    run_step("step1");
    mon_sel = 2'd0; @(posedge clk); #1;
    check("step1:v0_anchor", mon_v, 8'hD3);

    // Second step_i two cycles into a busy step
    step_i = 1'b1; @(posedge clk); #1; step_i = 1'b0;
    @(posedge clk); #1;
    step_i = 1'b1; @(posedge clk); #1; step_i = 1'b0;
    check("ovr:overrun", overrun_o, 1);
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (done_o) dones++;
      @(posedge clk); #1;
    end
    check("ovr:done_count", dones, 1);
    model_step();
    check("ovr:spike", spike_o, mspike);
    check_mon("ovr");

    // Configuration write while busy is dropped, then lands once idle
    step_i = 1'b1; @(posedge clk); #1; step_i = 1'b0;
    check("drop:ready", cfg_if.cfg_ready, 0);
    cfg_write(0, 5, 'h10000, 1'b0);
    wait_done("drop", 2);
    model_step();
    check_mon("drop");
    check("idle:ready", cfg_if.cfg_ready, 1);
    cfg_write(0, 5, 'h10000, 1'b1);
    check_mon("land");

    // Strong drive on neuron 2 until it fires, then one more step
    cfg_write(2, 4, 'h1FFFF, 1'b1);
    seen = 1'b0;
    for (int s = 0; s < 30 && !seen; s++) begin
      run_step($sformatf("drive%0d", s));
      if (spike_o[2]) seen = 1'b1;
    end
    check("drive:spike2_seen", seen, 1);
    run_step("after_spike");

    // Negative saturation of v on neuron 3
    cfg_write(3, 5, 'h20000, 1'b1);
    cfg_write(3, 6, 'h1FFFF, 1'b1);
    cfg_write(3, 4, 'h20000, 1'b1);
    run_step("negsat");
    mon_sel = 2'd3; @(posedge clk); #1;
    check("negsat:v3", mon_v, 8'h80);

    // u + d saturation on neuron 1, observed through the following v update
    cfg_write(1, 5, 'h1FFFF, 1'b1);
    cfg_write(1, 6, 'h1FFFF, 1'b1);
    cfg_write(1, 3, 'h1FFFF, 1'b1);
    cfg_write(1, 2, 0, 1'b1);
    cfg_write(1, 4, 0, 1'b1);
    run_step("usat1");
    run_step("usat2");
    mon_sel = 2'd1; @(posedge clk); #1;
    check("usat:v1", mon_v, 8'hFD);

`ifdef REFRACTORY_EN
    cfg_write(0, 2, 0, 1'b1);
    cfg_write(0, 4, 0, 1'b1);
    cfg_write(0, 5, 'h1FFFF, 1'b1);
    run_step("refr_fire");
    cfg_write(0, 5, 'h1FFFF, 1'b1);
    for (int s = 0; s < 4; s++) run_step($sformatf("refr%0d", s));
`endif

    // Randomised configuration and stepping
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 3; w++)
        cfg_write(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, 7)),
                  int'($urandom & 'h3FFFF), 1'b1);
      run_step($sformatf("rnd%0d", it));
    end
    check("final:overrun_sticky", overrun_o, 1);

    // Reset in the middle of a step abandons it
    step_i = 1'b1; @(posedge clk); #1; step_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; @(posedge clk); #1;
    check("midrst:busy", busy_o, 0);
    check("midrst:overrun", overrun_o, 0);
    check("midrst:spike", spike_o, 0);
    rst_n = 1'b1;
    model_reset();
    check_mon("midrst");
    repeat (NN + 2) @(posedge clk);
    #1;
    check("midrst:no_done", done_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
